// File: rtl/rbus_gen.sv
// rbus_gen: per-lane routing bus generator.
// A configuration handshake (Set_Conf / Set_Conf_Already / Ok) programs one lane per cycle.
// Each lane gets a channel select and an enable. The four control buses are then routed
// through the resulting table to the output lanes.
// Optional macro RBUS_GEN_OUT_REG_EN registers the Om_* buses and delays Set_Conf_Already
// by one cycle so that the two stay aligned.
module rbus_gen #(
  parameter int NUM_IN              = 13,
  parameter int LENGTHBUS           = 9,
  parameter int BITWIDTH_W_COLUMS   = 4,
  parameter int BITWIDTH_MAX_W_SIZE = 9
) (
  input  logic                           RBUS_Clk,
  input  logic                           RBUS_Reset,
  input  logic                           RBUS_Set_Conf,
  input  logic                           RBUS_Set_Conf_Already_Ok,
  input  logic [BITWIDTH_W_COLUMS-1:0]   RBUS_W_Colums,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0] RBUS_W_ROXCL,
  input  logic [NUM_IN-1:0]              RBUS_SetEn,
  input  logic [NUM_IN-1:0]              RBUS_OEn,
  input  logic [NUM_IN-1:0]              RBUS_Wptclr,
  input  logic [NUM_IN-1:0]              RBUS_Rptclr,
  output logic [LENGTHBUS-1:0]           RBUS_Om_SetEn,
  output logic [LENGTHBUS-1:0]           RBUS_Om_OEn,
  output logic [LENGTHBUS-1:0]           RBUS_Om_Wptclr,
  output logic [LENGTHBUS-1:0]           RBUS_Om_Rptclr,
  output logic                           RBUS_Set_Conf_Already,
  output logic                           RBUS_Busy,
  output logic                           RBUS_Conf_Err
);

  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int LANE_W = (LENGTHBUS > 1) ? $clog2(LENGTHBUS) : 1;
  localparam int COL_W  = (SEL_W > BITWIDTH_W_COLUMS) ? SEL_W : BITWIDTH_W_COLUMS;
  localparam int CMP_W  = (LANE_W > BITWIDTH_MAX_W_SIZE) ? LANE_W : BITWIDTH_MAX_W_SIZE;
  localparam int XW     = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, CONFIG, DONE, ACTIVE} state_t;

  state_t state, state_next;

  logic                           conf_prev;
  logic                           conf_rise;
  logic                           accept;
  logic                           busy;
  logic                           done;
  logic                           in_valid;
  logic                           lane_en;
  logic                           last_lane;
  logic                           col_last;
  logic                           conf_err;
  logic [BITWIDTH_W_COLUMS-1:0]   cols_shadow;
  logic [BITWIDTH_MAX_W_SIZE-1:0] roxcl_shadow;
  logic [LANE_W-1:0]              lane_cnt;
  logic [COL_W-1:0]               col_cnt;
  logic [SEL_W-1:0]               sel [LENGTHBUS];
  logic [LENGTHBUS-1:0]           en;
  logic [XW-1:0]                  set_ext, oen_ext, wpt_ext, rpt_ext;
  logic [LENGTHBUS-1:0]           route_set, route_oen, route_wpt, route_rpt;

  assign conf_rise = RBUS_Set_Conf & ~conf_prev;

  // Zero-extend the channel buses so that any select value indexes a defined bit.
  assign set_ext = XW'(RBUS_SetEn);
  assign oen_ext = XW'(RBUS_OEn);
  assign wpt_ext = XW'(RBUS_Wptclr);
  assign rpt_ext = XW'(RBUS_Rptclr);

  // A column count is usable only if it is nonzero and names existing channels.
  assign in_valid = (RBUS_W_Colums != '0) &&
                    ({1'b0, COL_W'(RBUS_W_Colums)} <= (COL_W+1)'(NUM_IN));

  // An error-free configuration enables every lane up to the last active index.
  assign lane_en   = (CMP_W'(lane_cnt) <= CMP_W'(roxcl_shadow)) & ~conf_err;
  assign last_lane = (lane_cnt == LANE_W'(LENGTHBUS - 1));
  assign col_last  = (col_cnt == (COL_W'(cols_shadow) - COL_W'(1)));

  // State register.
  always_ff @(posedge RBUS_Clk or negedge RBUS_Reset) begin
    if (!RBUS_Reset) state <= IDLE;
    else             state <= state_next;
  end

  // Next-state logic: Set_Conf edges are honoured only when no configuration is pending.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACTIVE: if (conf_rise) state_next = CONFIG;
      CONFIG:       if (last_lane) state_next = DONE;
      DONE:         if (RBUS_Set_Conf_Already_Ok) state_next = ACTIVE;
      default:      state_next = IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    busy   = (state == CONFIG);
    done   = (state == DONE);
    accept = conf_rise & ((state == IDLE) | (state == ACTIVE));
  end

  // Capture the configuration on acceptance, then fill the routing table one lane per cycle.
  always_ff @(posedge RBUS_Clk or negedge RBUS_Reset) begin
    if (!RBUS_Reset) begin
      conf_prev    <= 1'b0;
      cols_shadow  <= '0;
      roxcl_shadow <= '0;
      lane_cnt     <= '0;
      col_cnt      <= '0;
      conf_err     <= 1'b0;
      en           <= '0;
      for (int k = 0; k < LENGTHBUS; k++) sel[k] <= '0;
    end else begin
      conf_prev <= RBUS_Set_Conf;
      if (accept) begin
        cols_shadow  <= RBUS_W_Colums;
        roxcl_shadow <= RBUS_W_ROXCL;
        conf_err     <= ~in_valid;
        en           <= '0;
        lane_cnt     <= '0;
        col_cnt      <= '0;
      end else if (busy) begin
        for (int k = 0; k < LENGTHBUS; k++) begin
          if (lane_cnt == LANE_W'(k)) begin
            sel[k] <= col_cnt[SEL_W-1:0];
            en[k]  <= lane_en;
          end
        end
        lane_cnt <= lane_cnt + 1'b1;
        col_cnt  <= col_last ? '0 : col_cnt + 1'b1;
      end
    end
  end

  // Route each lane from its selected channel; disabled lanes stay low.
  always_comb begin
    route_set = '0;
    route_oen = '0;
    route_wpt = '0;
    route_rpt = '0;
    for (int k = 0; k < LENGTHBUS; k++) begin
      route_set[k] = en[k] & set_ext[sel[k]];
      route_oen[k] = en[k] & oen_ext[sel[k]];
      route_wpt[k] = en[k] & wpt_ext[sel[k]];
      route_rpt[k] = en[k] & rpt_ext[sel[k]];
    end
  end

`ifdef RBUS_GEN_OUT_REG_EN
  logic [LENGTHBUS-1:0] om_set_q, om_oen_q, om_wpt_q, om_rpt_q;
  logic                 already_q;

  // Output register stage; the handshake flag is delayed with the data.
  always_ff @(posedge RBUS_Clk or negedge RBUS_Reset) begin
    if (!RBUS_Reset) begin
      om_set_q  <= '0;
      om_oen_q  <= '0;
      om_wpt_q  <= '0;
      om_rpt_q  <= '0;
      already_q <= 1'b0;
    end else begin
      om_set_q  <= route_set;
      om_oen_q  <= route_oen;
      om_wpt_q  <= route_wpt;
      om_rpt_q  <= route_rpt;
      already_q <= done;
    end
  end

  assign RBUS_Om_SetEn         = om_set_q;
  assign RBUS_Om_OEn           = om_oen_q;
  assign RBUS_Om_Wptclr        = om_wpt_q;
  assign RBUS_Om_Rptclr        = om_rpt_q;
  assign RBUS_Set_Conf_Already = already_q;
`else
  assign RBUS_Om_SetEn         = route_set;
  assign RBUS_Om_OEn           = route_oen;
  assign RBUS_Om_Wptclr        = route_wpt;
  assign RBUS_Om_Rptclr        = route_rpt;
  assign RBUS_Set_Conf_Already = done;
`endif

  assign RBUS_Busy     = busy;
  assign RBUS_Conf_Err = conf_err;

endmodule

// File: doc/rbus_gen.md
RBUS_GEN -- requirements
Module: rbus_gen

Interface
REQ-001 SHALL have parameter NUM_IN, default 13, meaning the number of input control channels.
REQ-002 SHALL have parameter LENGTHBUS, default 9, meaning the number of output lanes.
REQ-003 SHALL have parameter BITWIDTH_W_COLUMS, default 4, meaning the width of the column-count input.
REQ-004 SHALL have parameter BITWIDTH_MAX_W_SIZE, default 9, meaning the width of the last-active-lane input.
REQ-005 SHALL have ports RBUS_Clk (in, 1, single clock, rising edge) and RBUS_Reset (in, 1); RBUS_Reset is asynchronous and active-low.
REQ-006 SHALL have RBUS_Set_Conf (in, 1): configuration request, accepted on its rising edge.
REQ-007 SHALL have RBUS_Set_Conf_Already_Ok (in, 1): acknowledge of configuration done.
REQ-008 SHALL have RBUS_W_Colums (in, BITWIDTH_W_COLUMS): number of active columns (kernel width).
REQ-009 SHALL have RBUS_W_ROXCL (in, BITWIDTH_MAX_W_SIZE): rows x columns - 1, the index of the last active lane.
REQ-010 SHALL have RBUS_SetEn, RBUS_OEn, RBUS_Wptclr and RBUS_Rptclr (in, NUM_IN each): per-channel control inputs.
REQ-011 SHALL have RBUS_Om_SetEn, RBUS_Om_OEn, RBUS_Om_Wptclr and RBUS_Om_Rptclr (out, LENGTHBUS each): routed lane outputs.
REQ-012 SHALL have RBUS_Set_Conf_Already (out, 1): configuration complete, awaiting acknowledge.
REQ-013 SHALL have RBUS_Busy (out, 1): high while configuration is in progress.
REQ-014 SHALL have RBUS_Conf_Err (out, 1): the latched configuration was invalid.

Function
REQ-015 SHALL hold a per-lane routing table: sel[k] (ceil(log2(NUM_IN)) bits) plus an enable bit en[k].
REQ-016 SHALL drive each output as Om_X[k] = en[k] & X[sel[k]], for every bus X in {SetEn, OEn, Wptclr, Rptclr}.
REQ-017 SHALL implement the FSM states IDLE, CONFIG, DONE and ACTIVE.
REQ-018 SHALL, on a rising edge of Set_Conf seen in IDLE or ACTIVE (registered previous value = 0, current = 1), in that same clock edge:
- capture W_Colums and W_ROXCL into shadow registers;
- clear every en[k];
- clear the lane counter and the column counter;
- enter CONFIG.
REQ-019 SHALL, in CONFIG, write one lane per cycle: lane k gets sel = column counter and en = (k <= W_ROXCL shadow) & valid configuration.
REQ-020 SHALL advance the column counter by 1 after each lane and wrap it to 0 when it reaches W_Colums - 1; no divider is used.
REQ-021 SHALL, after lane LENGTHBUS-1 is written, enter DONE; RBUS_Set_Conf_Already goes high exactly LENGTHBUS cycles after the acceptance edge.
REQ-022 SHALL assert RBUS_Busy exactly while in CONFIG.
REQ-023 SHALL hold Set_Conf_Already high in DONE until Set_Conf_Already_Ok is sampled high; then deassert it and enter ACTIVE on the next edge.
REQ-024 SHALL ignore Set_Conf_Already_Ok in any state other than DONE.
REQ-025 SHALL ignore Set_Conf edges while in CONFIG or DONE.
REQ-026 SHALL ignore changes to W_Colums and W_ROXCL after capture.
REQ-027 SHALL treat W_Colums == 0 or W_Colums > NUM_IN as invalid:
- Conf_Err is set at the acceptance edge;
- all lanes stay disabled;
- the CONFIG/DONE handshake still completes;
- Conf_Err clears at the next accepted Set_Conf edge with a valid configuration.
REQ-028 SHALL leave lanes that do not exist (W_ROXCL >= LENGTHBUS) absent, with no error raised.
REQ-029 SHALL keep outputs 0 during CONFIG and DONE for lanes not yet written.
REQ-030 SHALL keep the routing live in DONE and ACTIVE: outputs follow input changes combinationally, with zero latency.

Reset
REQ-031 SHALL, on RBUS_Reset low, immediately and asynchronously:
- set the state to IDLE;
- clear all en[k], all sel[k], both counters, the shadow registers and the Set_Conf edge register;
- drive every Om_* output, Set_Conf_Already, Busy and Conf_Err to 0.
REQ-032 SHALL, when reset is asserted mid-CONFIG or in DONE, abandon the configuration; a new Set_Conf rising edge is required afterwards.

Configuration
REQ-033 SHALL, with macro RBUS_GEN_OUT_REG_EN defined, register all four Om_* buses: inputs reach the outputs one clock later, the register resets to 0, and Set_Conf_Already is also delayed 1 cycle so that it stays aligned with the outputs.
REQ-034 SHALL, with RBUS_GEN_OUT_REG_EN undefined, keep the Om_* outputs combinational as described in REQ-016.

Verification
REQ-035 SHALL cover: defaults, W_Colums=3, W_ROXCL=8, SetEn/OEn/Wptclr/Rptclr[2:0]=1, others 0, Set_Conf rises -> Busy for 9 cycles, Set_Conf_Already at +9, all Om_* = 9'h1FF; Ok pulse -> Set_Conf_Already low next edge, state ACTIVE.
REQ-036 SHALL cover: W_Colums=2, W_ROXCL=4, SetEn=13'b01 -> Om_SetEn = 9'b0_0001_0101; SetEn=13'b10 -> 9'b0_0000_1010.
REQ-037 SHALL cover: W_Colums=0 -> Conf_Err=1, handshake completes, all Om_* = 0; reconfigure with W_Colums=3 -> Conf_Err=0.
REQ-038 SHALL cover: Set_Conf held high across Ok -> no second configuration; Set_Conf toggling during CONFIG and Ok before DONE -> ignored, Set_Conf_Already timing unchanged.
REQ-039 SHALL cover: reset asserted at CONFIG lane 4 -> all outputs 0 asynchronously; after release, no activity until a new Set_Conf edge.
REQ-040 SHALL cover: with RBUS_GEN_OUT_REG_EN defined, a step on RBUS_OEn[0] -> Om_OEn[0] changes 1 cycle later.
